// File: rtl/serial_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : serial_pkg
//  Description : Shared constants, receiver FSM state encoding and bit-timing
//                helper for the 8N1 serial receive path.
//  Revision    : 1.0 - initial release
// ============================================================================
package serial_pkg;

    // 8N1 framing
    localparam int   c_DATA_BITS = 8;
    localparam logic c_LINE_IDLE = 1'b1;
    localparam logic c_START_BIT = 1'b0;
    localparam logic c_STOP_BIT  = 1'b1;

    // Receiver FSM states
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_STOP      = 3'd3,
        ST_WAIT_IDLE = 3'd4
    } rx_state_t;

    // Clock cycles per bit period, truncated
    function automatic int clks_per_bit(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fifo
//  Description : First-word fall-through FIFO with valid/ready read side,
//                occupancy output and an overrun strobe for pushes that
//                find the FIFO full with no simultaneous pop.
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_push_data,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_valid,
    input  logic                     i_ready,
    output logic [$clog2(DEPTH):0]   o_level,
    output logic                     o_overrun
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] c_PTR_ONE = 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;

    logic             w_empty;
    logic             w_full;
    logic             w_pop;
    logic             w_wr_en;

    // Pointers carry one extra wrap bit so full and empty are distinguishable
    assign w_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_pop     = ~w_empty & i_ready;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands
    assign w_wr_en   = i_push & (~w_full | w_pop);
    assign o_overrun = i_push & w_full & ~w_pop;

    assign o_valid   = ~w_empty;
    assign o_level   = r_wr_ptr - r_rd_ptr;
    // Head entry is driven straight from storage; forced to zero while empty
    assign o_data    = w_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

    // Pointer update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr_en) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            if (w_pop)   r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
        end
    end

    // Storage write; contents need no reset because reads are gated by empty
    always_ff @(posedge clk) begin
        if (w_wr_en) r_mem[r_wr_ptr[AW-1:0]] <= i_push_data;
    end

endmodule
`default_nettype wire

// File: rtl/serial_rx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : serial_rx_fifo
//  Description : 8N1 asynchronous serial receiver feeding a byte FIFO that
//                is presented as a valid/ready stream. Flags framing errors
//                (stop bit low) and overruns (byte arrives with FIFO full).
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_rx_fifo
    import serial_pkg::*;
#(
    parameter int CLK_HZ     = 16_000_000,
    parameter int BAUD       = 115_200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          rx_i,
    output logic [7:0]                    data_o,
    output logic                          valid_o,
    input  logic                          ready_i,
    output logic [$clog2(FIFO_DEPTH):0]   level_o,
    output logic                          busy_o,
    output logic                          frame_err_o,
    output logic                          overrun_o
);

    localparam int CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD);
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);
    localparam int BIT_W        = $clog2(c_DATA_BITS);

    localparam logic [CNT_W-1:0] c_HALF_LOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] c_FULL_LOAD = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] c_CNT_ONE   = 1;
    localparam logic [BIT_W-1:0] c_BIT_ONE   = 1;
    localparam logic [BIT_W-1:0] c_LAST_BIT  = BIT_W'(c_DATA_BITS - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_sync_prev;
    rx_state_t        r_state;
    rx_state_t        w_state_next;
    logic [CNT_W-1:0] r_baud_cnt;
    logic [BIT_W-1:0] r_bit_cnt;
    logic [7:0]       r_shift;
    logic             r_push;
    logic [7:0]       r_push_data;
    logic             r_frame_err;

    logic             w_tick;
    logic             w_fall;
    logic             w_load_half;
    logic             w_load_full;
    logic             w_sample_bit;
    logic             w_push;
    logic             w_ferr;

    // Two-flop synchroniser plus one history flop for falling-edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1     <= c_LINE_IDLE;
            r_sync2     <= c_LINE_IDLE;
            r_sync_prev <= c_LINE_IDLE;
        end else begin
            r_sync1     <= rx_i;
            r_sync2     <= r_sync1;
            r_sync_prev <= r_sync2;
        end
    end

    assign w_fall = r_sync_prev & ~r_sync2;
    assign w_tick = (r_baud_cnt == '0);

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_next;
    end

    // FSM next state and datapath strobes
    always_comb begin
        w_state_next = r_state;
        w_load_half  = 1'b0;
        w_load_full  = 1'b0;
        w_sample_bit = 1'b0;
        w_push       = 1'b0;
        w_ferr       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_fall) begin
                    w_state_next = ST_START;
                    w_load_half  = 1'b1;
                end
            end
            ST_START: begin
                if (w_tick) begin
                    if (r_sync2 == c_START_BIT) begin
                        w_state_next = ST_DATA;
                        w_load_full  = 1'b1;
                    end else begin
                        // Line back high at mid start bit: a glitch, not a frame
                        w_state_next = ST_IDLE;
                    end
                end
            end
            ST_DATA: begin
                if (w_tick) begin
                    w_sample_bit = 1'b1;
                    w_load_full  = 1'b1;
                    if (r_bit_cnt == c_LAST_BIT) w_state_next = ST_STOP;
                end
            end
            ST_STOP: begin
                if (w_tick) begin
                    if (r_sync2 == c_STOP_BIT) begin
                        w_push       = 1'b1;
                        w_state_next = ST_IDLE;
                    end else begin
                        w_ferr       = 1'b1;
                        w_state_next = ST_WAIT_IDLE;
                    end
                end
            end
            ST_WAIT_IDLE: begin
                // A held-low line (break) must not be mistaken for a new start bit
                if (r_sync2 == c_LINE_IDLE) w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Baud counter: half a bit to reach mid start bit, then whole bits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)           r_baud_cnt <= '0;
        else if (w_load_half) r_baud_cnt <= c_HALF_LOAD;
        else if (w_load_full) r_baud_cnt <= c_FULL_LOAD;
        else if (!w_tick)     r_baud_cnt <= r_baud_cnt - c_CNT_ONE;
    end

    // Bit counter and LSB-first shift register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bit_cnt <= '0;
            r_shift   <= '0;
        end else if (w_load_half) begin
            r_bit_cnt <= '0;
        end else if (w_sample_bit) begin
            r_bit_cnt <= r_bit_cnt + c_BIT_ONE;
            r_shift   <= {r_sync2, r_shift[7:1]};
        end
    end

    // Stop-bit outcome registered: push or framing error lands one cycle later
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_push      <= 1'b0;
            r_push_data <= '0;
            r_frame_err <= 1'b0;
        end else begin
            r_push      <= w_push;
            r_frame_err <= w_ferr;
            if (w_push) r_push_data <= r_shift;
        end
    end

    assign busy_o      = (r_state != ST_IDLE);
    assign frame_err_o = r_frame_err;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (r_push),
        .i_push_data (r_push_data),
        .o_data      (data_o),
        .o_valid     (valid_o),
        .i_ready     (ready_i),
        .o_level     (level_o),
        .o_overrun   (overrun_o)
    );

endmodule
`default_nettype wire
